gray_code_pipe: RTL and testbench

Parametrised, pipelined Gray/binary code converter with a valid/ready stream interface, per-beat conversion mode and a Gray-sequence step checker. It sits between pointer or position sources (CDC FIFO pointers, encoders) and binary consumers. It converts either direction at a configurable width and pipeline depth. In Gray-to-binary mode it flags input sequences that violate the single-bit-change property.

---
 rtl/gray_code_pipe_if.sv | 27 ++
 rtl/gray_code_pipe.sv | 108 ++++++++++
 tb/tb_gray_code_pipe.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gray_code_pipe_if.sv
// Stream bundle for gray_code_pipe: input beat channel, output beat channel
// and the step-error counter readout.
interface gray_code_pipe_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_mode;
    logic             out_step_err;
    logic [CNT_W-1:0] err_count;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_mode, out_step_err, err_count
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_mode, out_step_err, err_count
    );
endinterface

// File: rtl/gray_code_pipe.sv
// Pipelined Gray<->binary converter with valid/ready stream, per-beat mode
// and a single-bit-step checker on the Gray->binary input sequence.
module gray_code_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 8
) (
    input logic              clk,
    input logic              rst,
    input logic              clr,
    gray_code_pipe_if.slave  bus
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [STAGES-1:0] st_valid;
    logic [WIDTH-1:0]  st_data [STAGES];
    logic [STAGES-1:0] st_mode;
    logic [STAGES-1:0] st_err;

    logic [WIDTH-1:0]  prev_gray;
    logic              have_prev;
    logic [CNT_W-1:0]  err_cnt;

    logic              adv;
    logic              accept;
    logic              step_err;
    logic [WIDTH-1:0]  conv;
    logic [WIDTH-1:0]  diff;

    assign adv          = !st_valid[STAGES-1] || bus.out_ready;
    assign bus.in_ready = adv && !clr;
    assign accept       = bus.in_valid && adv && !clr;

    always_comb begin
        conv = '0;
        if (bus.in_mode) begin
            conv = bus.in_data ^ (bus.in_data >> 1);
        end else begin
            conv[WIDTH-1] = bus.in_data[WIDTH-1];
            for (int unsigned i = 2; i <= WIDTH; i++) begin
                conv[WIDTH-i] = bus.in_data[WIDTH-i] ^ conv[WIDTH-i+1];
            end
        end
    end

    // More than one bit set in diff <=> clearing its lowest set bit leaves a nonzero value.
    assign diff     = bus.in_data ^ prev_gray;
    assign step_err = have_prev && !bus.in_mode && ((diff & (diff - ONE)) != '0);

    // Data/mode/err only load behind a valid beat, so bubbles never disturb held outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_valid <= '0;
            st_mode  <= '0;
            st_err   <= '0;
            for (int unsigned s = 0; s < STAGES; s++) begin
                st_data[s] <= '0;
            end
        end else if (clr) begin
            st_valid <= '0;
        end else if (adv) begin
            st_valid[0] <= accept;
            if (accept) begin
                st_data[0] <= conv;
                st_mode[0] <= bus.in_mode;
                st_err[0]  <= step_err;
            end
            for (int unsigned s = 1; s < STAGES; s++) begin
                st_valid[s] <= st_valid[s-1];
                if (st_valid[s-1]) begin
                    st_data[s] <= st_data[s-1];
                    st_mode[s] <= st_mode[s-1];
                    st_err[s]  <= st_err[s-1];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_gray <= '0;
            have_prev <= 1'b0;
        end else if (clr) begin
            prev_gray <= '0;
            have_prev <= 1'b0;
        end else if (accept && !bus.in_mode) begin
            prev_gray <= bus.in_data;
            have_prev <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (clr) begin
            err_cnt <= '0;
        end else if (st_valid[STAGES-1] && bus.out_ready && st_err[STAGES-1]
                     && (err_cnt != '1)) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

    assign bus.out_valid    = st_valid[STAGES-1];
    assign bus.out_data     = st_data[STAGES-1];
    assign bus.out_mode     = st_mode[STAGES-1];
    assign bus.out_step_err = st_err[STAGES-1];
    assign bus.err_count    = err_cnt;
endmodule

// File: tb/tb_gray_code_pipe.sv
// Scoreboard bench for gray_code_pipe: accepted beats push expected results,
// handed-off beats pop and compare; per-scenario tasks add targeted checks.
module tb_gray_code_pipe;
    localparam int W = 8;
    localparam int S = 2;
    localparam int C = 8;

    typedef struct packed {
        logic [W-1:0] d;
        logic         m;
        logic         e;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    logic clr_s = 1'b0;

    gray_code_pipe_if #(.WIDTH(W), .CNT_W(C)) bus ();
    gray_code_pipe_if #(.WIDTH(W), .CNT_W(2)) sbus ();

    gray_code_pipe #(.WIDTH(W), .STAGES(S), .CNT_W(C)) dut (
        .clk(clk), .rst(rst), .clr(clr), .bus(bus)
    );
    gray_code_pipe #(.WIDTH(W), .STAGES(S), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .clr(clr_s), .bus(sbus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    beat_t        q[$];
    beat_t        mon_exp;
    beat_t        mon_got;
    beat_t        mon_new;
    logic [W-1:0] m_prev = '0;
    logic         m_have = 1'b0;
    logic [C-1:0] exp_cnt = '0;

    function automatic logic [W-1:0] ref_g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = g;
        for (int sh = 1; sh < W; sh = sh * 2) b = b ^ (b >> sh);
        return b;
    endfunction

    function automatic logic [W-1:0] ref_b2g(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            m_have  = 1'b0;
            exp_cnt = '0;
        end else begin
            n_tests++;
            if (bus.err_count !== exp_cnt) begin
                n_fail++;
                $display("FAIL err_count_track: got %0d expected %0d", bus.err_count, exp_cnt);
            end
            if (clr) begin
                q.delete();
                m_have  = 1'b0;
                exp_cnt = '0;
            end else begin
                if (bus.out_valid && bus.out_ready) begin
                    n_tests++;
                    if (q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_beat: got data %h with no beat expected", bus.out_data);
                    end else begin
                        mon_exp = q.pop_front();
                        mon_got = '{d: bus.out_data, m: bus.out_mode, e: bus.out_step_err};
                        if (mon_got !== mon_exp) begin
                            n_fail++;
                            $display("FAIL beat: got data %h mode %b err %b expected data %h mode %b err %b",
                                     mon_got.d, mon_got.m, mon_got.e, mon_exp.d, mon_exp.m, mon_exp.e);
                        end
                        if (mon_exp.e && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
                    end
                end
                if (bus.in_valid && bus.in_ready) begin
                    mon_new.m = bus.in_mode;
                    if (bus.in_mode) begin
                        mon_new.d = ref_b2g(bus.in_data);
                        mon_new.e = 1'b0;
                    end else begin
                        mon_new.d = ref_g2b(bus.in_data);
                        mon_new.e = m_have && ($countones(bus.in_data ^ m_prev) > 1);
                        m_prev    = bus.in_data;
                        m_have    = 1'b1;
                    end
                    q.push_back(mon_new);
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] d, input logic m);
        int unsigned n;
        logic acc;
        n = 0;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_mode  = m;
        do begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 100);
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready 0 expected accept of %h", d);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int unsigned n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d beats pending expected 0", q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_tests += 6;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
        if (bus.out_data !== '0) begin n_fail++; $display("FAIL rst_out_data: got %h expected 00", bus.out_data); end
        if (bus.out_mode !== 1'b0) begin n_fail++; $display("FAIL rst_out_mode: got %b expected 0", bus.out_mode); end
        if (bus.out_step_err !== 1'b0) begin n_fail++; $display("FAIL rst_step_err: got %b expected 0", bus.out_step_err); end
        if (bus.err_count !== '0) begin n_fail++; $display("FAIL rst_err_count: got %0d expected 0", bus.err_count); end
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", bus.in_ready); end
        @(posedge clk);
        #1 rst = 1'b0;
        n_tests++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_latency();
        logic [W-1:0] gin [3];
        logic [W-1:0] bexp [3];
        gin  = '{8'h06, 8'h80, 8'h03};
        bexp = '{8'h04, 8'hFF, 8'h02};
        for (int i = 0; i < 3; i++) begin
            wait_empty();
            bus.in_valid = 1'b1;
            bus.in_data  = gin[i];
            bus.in_mode  = 1'b0;
            n_tests++;
            if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_idle[%0d]: got out_valid %b expected 0", i, bus.out_valid); end
            @(posedge clk);
            #1 bus.in_valid = 1'b0;
            n_tests++;
            if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_early[%0d]: got out_valid %b expected 0", i, bus.out_valid); end
            @(posedge clk);
            #1;
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== bexp[i]) begin
                n_fail++;
                $display("FAIL lat_result[%0d]: got valid %b data %h expected valid 1 data %h",
                         i, bus.out_valid, bus.out_data, bexp[i]);
            end
        end
        wait_empty();
    endtask

    task automatic test_exhaustive();
        for (int i = 0; i < 256; i++) send(W'(i), 1'b0);
        wait_empty();
    endtask

    task automatic test_b2g();
        send(8'h0B, 1'b1);
        send(8'hFF, 1'b1);
        wait_empty();
        n_tests++;
        if (bus.out_data !== 8'h80 || bus.out_mode !== 1'b1 || bus.out_step_err !== 1'b0) begin
            n_fail++;
            $display("FAIL b2g_last: got data %h mode %b err %b expected 80 1 0",
                     bus.out_data, bus.out_mode, bus.out_step_err);
        end
    endtask

    task automatic test_step();
        pulse_clr();
        send(8'h00, 1'b0);
        send(8'h01, 1'b0);
        send(8'h03, 1'b0);
        send(8'h00, 1'b0);
        wait_empty();
        n_tests += 2;
        if (bus.out_step_err !== 1'b1) begin n_fail++; $display("FAIL step_4th: got %b expected 1", bus.out_step_err); end
        if (bus.err_count !== 8'd1) begin n_fail++; $display("FAIL step_count: got %0d expected 1", bus.err_count); end
        pulse_clr();
        send(8'h05, 1'b0);
        wait_empty();
        n_tests += 3;
        if (bus.out_step_err !== 1'b0) begin n_fail++; $display("FAIL step_after_clr: got %b expected 0", bus.out_step_err); end
        if (bus.out_data !== 8'h06) begin n_fail++; $display("FAIL step_after_clr_data: got %h expected 06", bus.out_data); end
        if (bus.err_count !== 8'd0) begin n_fail++; $display("FAIL step_clr_count: got %0d expected 0", bus.err_count); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held;
        pulse_clr();
        fork
            begin
                for (int i = 0; i < 10; i++) send(W'(8'h10 + i), 1'b1);
            end
            begin
                repeat (4) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    held = bus.out_data;
                    n_tests += 2;
                    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b expected 1", k, bus.out_valid); end
                    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", k, bus.in_ready); end
                    @(posedge clk);
                    #1;
                    n_tests++;
                    if (bus.out_data !== held) begin n_fail++; $display("FAIL bp_hold[%0d]: got %h expected %h", k, bus.out_data, held); end
                end
                bus.out_ready = 1'b1;
            end
        join
        wait_empty();
    endtask

    task automatic test_reset_mid();
        send(8'h00, 1'b0);
        send(8'h03, 1'b0);
        wait_empty();
        n_tests++;
        if (bus.err_count !== 8'd1) begin n_fail++; $display("FAIL rm_pre_count: got %0d expected 1", bus.err_count); end
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        rst = 1'b1;
        #1;
        n_tests += 2;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_out_valid: got %b expected 0", bus.out_valid); end
        if (bus.err_count !== 8'd0) begin n_fail++; $display("FAIL rm_err_count: got %0d expected 0", bus.err_count); end
        @(posedge clk);
        #1 rst = 1'b0;
        send(8'h0F, 1'b0);
        wait_empty();
        n_tests += 3;
        if (bus.out_step_err !== 1'b0) begin n_fail++; $display("FAIL rm_first_gray: got %b expected 0", bus.out_step_err); end
        if (bus.out_data !== 8'h0A) begin n_fail++; $display("FAIL rm_first_data: got %h expected 0A", bus.out_data); end
        if (bus.err_count !== 8'd0) begin n_fail++; $display("FAIL rm_final_count: got %0d expected 0", bus.err_count); end
    endtask

    task automatic test_saturation();
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            sbus.in_valid = 1'b1;
            sbus.in_data  = (i % 2 == 1) ? 8'h03 : 8'h00;
            @(posedge clk);
            #1;
        end
        sbus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_tests += 2;
        if (sbus.err_count !== 2'd3) begin n_fail++; $display("FAIL sat_count: got %0d expected 3", sbus.err_count); end
        if (sbus.out_step_err !== 1'b1) begin n_fail++; $display("FAIL sat_last_err: got %b expected 1", sbus.out_step_err); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_mode    = 1'b0;
        bus.out_ready  = 1'b1;
        sbus.in_valid  = 1'b0;
        sbus.in_data   = '0;
        sbus.in_mode   = 1'b0;
        sbus.out_ready = 1'b1;
        test_reset();
        test_latency();
        test_exhaustive();
        test_b2g();
        test_step();
        test_backpressure();
        test_reset_mid();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
